ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 5, RAM word-address width (32 words).
REQ-002 Parameter DATA_WIDTH, 32, RAM data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clock  input  1  single clock; all state changes on rising edge.
- resetn  input  1  synchronous active-low reset.
- req0, req1  input  1 each  access request; held high until the matching ack.
- we0, we1  input  1 each  1 = write, 0 = read; stable while req high.
- addr0, addr1  input  ADDR_WIDTH each  word address; stable while req high.
- wdata0, wdata1  input  DATA_WIDTH each  write data; stable while req high.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata0, rdata1  output  DATA_WIDTH each  read result, valid when ack is high.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_input_data  output  DATA_WIDTH  to RAM write data.
- ram_write_enabled  output  1  to RAM write enable.
- ram_output_data  input  DATA_WIDTH  from RAM; valid one clock after the address is sampled.
- busy  output  1  high in any state other than IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS, READ and DONE; exactly one transaction is in flight at a time.
REQ-005 In IDLE, the block SHALL stay in IDLE when there is no request.
REQ-006 In IDLE with any request, the block SHALL select a winner, register its addr/wdata/we into the ram_* outputs, and go to ACCESS.
REQ-007 In ACCESS, the ram_* outputs SHALL be driven from the registered winner values; the RAM samples them at the end of ACCESS. Then go to READ.
REQ-008 ram_write_enabled SHALL be high only during ACCESS, and only for a write; it SHALL be 0 in all other states.
REQ-009 In READ, ram_output_data is valid; at the end of READ, a read SHALL latch it into the winner's rdata, and the FSM SHALL go to DONE.
REQ-010 In DONE, the winner's ack SHALL be high for exactly one cycle; then go to IDLE.
REQ-011 Latency: req sampled high in IDLE at cycle T -> ack high in cycle T+3; back-to-back throughput is one transaction per 4 cycles.
REQ-012 A write SHALL leave the winner's rdata unchanged.
REQ-013 A non-winner's rdata and ack SHALL be unaffected by the current transaction.
REQ-014 Arbitration SHALL be round-robin, tracked by a register last (1 bit):
- Only one requester high -> it wins.
- Both high -> the requester other than last wins.
- last SHALL update to the winner at the IDLE->ACCESS transition.
REQ-015 Requester rule: after its ack, a requester SHALL have req low, or present a new transaction, in the following IDLE cycle; the arbiter SHALL NOT hold or replay a completed transaction.
REQ-016 A request that is raised while the FSM is not in IDLE SHALL wait; it is evaluated at the next IDLE cycle.
REQ-017 Changes to a winner's req/addr/we/wdata after it was sampled in IDLE SHALL have no effect on the in-flight transaction.
REQ-018 ack0 and ack1 SHALL never be high in the same cycle.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 Address range is the full 0..2^ADDR_WIDTH-1; there is no wrap-around or address translation.

Reset
REQ-021 When resetn is low at a rising edge, the block SHALL set the following at that edge:
- state = IDLE;
- last = 1, so requester 0 wins the first contention;
- ack0 = ack1 = 0;
- ram_write_enabled = 0;
- ram_address = 0 and ram_input_data = 0;
- rdata0 = rdata1 = 0;
- busy = 0.
REQ-022 A reset during ACCESS, READ or DONE SHALL abort the transaction with no ack. Any write whose ACCESS edge coincides with the reset edge SHALL NOT be issued, because ram_write_enabled is 0 after that edge.

Verification
REQ-023 Single write then read: req0 writes addr 5 = 0xDEADBEEF -> ack0 at T+3 with ram_write_enabled high only in T+1. Then req0 reads addr 5 -> ack0 at T+3 with rdata0 = 0xDEADBEEF.
REQ-024 Contention after reset: req0 and req1 both raised at T, reading addr 1 and addr 2 -> ack0 at T+3 and ack1 at T+7; rdata1 = contents of addr 2; rdata0 is unchanged while requester 1 is served.
REQ-025 Round-robin fairness: req0 and req1 held continuously, re-requesting after each ack, for 8 transactions -> grants alternate 0,1,0,1,...; no requester is granted twice in a row.
REQ-026 Request during busy: req1 raised at T+1 while requester 0 is in ACCESS -> requester 1 is granted in the IDLE cycle T+4 and ack1 is at T+7.
REQ-027 Reset mid-write: resetn low during the ACCESS cycle of a write of 0x12345678 to addr 9 ->
- no ack;
- busy = 0 and ram_write_enabled = 0 after the edge;
- a subsequent read of addr 9 returns the prior contents.
REQ-028 Bench checks SHALL run on every cycle:
- ack0 and ack1 are never high together;
- ram_write_enabled is never high outside ACCESS.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of requester, RAM and status signals shared by ram_arbiter and its environment.
// The slave modport is the arbiter's view; master is the requesters-plus-RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_input_data;
  logic                  ram_write_enabled;
  logic [DATA_WIDTH-1:0] ram_output_data;
  logic                  busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_output_data,
    output ack0, ack1, rdata0, rdata1, ram_address, ram_input_data,
           ram_write_enabled, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_output_data,
    input  ack0, ack1, rdata0, rdata1, ram_address, ram_input_data,
           ram_write_enabled, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One transaction at a time: IDLE -> ACCESS -> READ -> DONE, ack in DONE.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clock,
  input  logic        resetn,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;

  state_t                state;
  logic                  last;
  logic                  winner;
  logic                  is_write;
  logic                  pick;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0] ram_input_data_q;
  logic                  ram_we_q;

  // With both requesting, the one that did not win last time goes next.
  always_comb begin
    pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state            <= IDLE;
      last             <= 1'b1;
      winner           <= 1'b0;
      is_write         <= 1'b0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      rdata0_q         <= '0;
      rdata1_q         <= '0;
      ram_address_q    <= '0;
      ram_input_data_q <= '0;
      ram_we_q         <= 1'b0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ram_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            winner           <= pick;
            last             <= pick;
            is_write         <= pick ? bus.we1 : bus.we0;
            ram_address_q    <= pick ? bus.addr1 : bus.addr0;
            ram_input_data_q <= pick ? bus.wdata1 : bus.wdata0;
            ram_we_q         <= pick ? bus.we1 : bus.we0;
            state            <= ACCESS;
          end
        end
        ACCESS: begin
          state <= READ;
        end
        READ: begin
          if (!is_write) begin
            if (winner) rdata1_q <= bus.ram_output_data;
            else        rdata0_q <= bus.ram_output_data;
          end
          if (winner) ack1_q <= 1'b1;
          else        ack0_q <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0              = ack0_q;
  assign bus.ack1              = ack1_q;
  assign bus.rdata0            = rdata0_q;
  assign bus.rdata1            = rdata1_q;
  assign bus.ram_address       = ram_address_q;
  assign bus.ram_input_data    = ram_input_data_q;
  assign bus.ram_write_enabled = ram_we_q;
  assign bus.busy              = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: stimulus pushes expected acks and write strobes
// into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_ram_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    int          port;
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int          cyc = 0;
  logic        rst_q = 1'b1;
  logic        armed = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          acks_seen = 0;
  logic [31:0] exp_rd0 = '0;
  logic [31:0] exp_rd1 = '0;
  ack_t        ackq[$];
  wr_t         wrq[$];
  logic [31:0] mem [32];

  logic        rr_we   [2][4];
  logic [4:0]  rr_addr [2][4];
  logic [31:0] rr_wd   [2][4];
  logic [31:0] rr_exp  [2][4];

  // Synchronous RAM: read data appears one clock after the address; writes are
  // ignored while the system is held in reset.
  always @(posedge clock) begin
    if (bus.ram_write_enabled && resetn) mem[bus.ram_address] <= bus.ram_input_data;
    bus.ram_output_data <= mem[bus.ram_address];
  end

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= resetn;
    if (!resetn) armed <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (armed) begin
      if (!rst_q) begin
        exp_rd0 = '0;
        exp_rd1 = '0;
        chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
        chk("rst_ack1", {31'd0, bus.ack1}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_we", {31'd0, bus.ram_write_enabled}, 32'd0);
        chk("rst_addr", {27'd0, bus.ram_address}, 32'd0);
        chk("rst_wdata", bus.ram_input_data, 32'd0);
      end
      chk("acks_exclusive", {31'd0, bus.ack0 && bus.ack1}, 32'd0);
      if (bus.ram_write_enabled) begin
        if (wrq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_write actual=we_high required=no_write at cycle %0d", cyc);
        end else begin
          wr_t w;
          w = wrq.pop_front();
          chk("we_cycle", cyc, w.cyc);
          chk("we_addr", {27'd0, bus.ram_address}, {27'd0, w.addr});
          chk("we_data", bus.ram_input_data, w.data);
          chk("we_busy", {31'd0, bus.busy}, 32'd1);
        end
      end
      if (bus.ack0 || bus.ack1) begin
        acks_seen++;
        if (ackq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_ack actual=ack0=%0b,ack1=%0b required=none at cycle %0d",
                   bus.ack0, bus.ack1, cyc);
        end else begin
          ack_t e;
          e = ackq.pop_front();
          chk("ack_port", bus.ack1 ? 32'd1 : 32'd0, e.port);
          chk("ack_cycle", cyc, e.cyc);
          if (e.rd) begin
            if (e.port == 1) exp_rd1 = e.data;
            else             exp_rd0 = e.data;
          end
        end
      end
      chk("rdata0", bus.rdata0, exp_rd0);
      chk("rdata1", bus.rdata1, exp_rd1);
    end
  end

  task automatic drive(input int p, input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic exp_ack(input int p, input int c, input bit rd, input logic [31:0] d);
    ack_t e;
    e.port = p; e.cyc = c; e.rd = rd; e.data = d;
    ackq.push_back(e);
  endtask

  task automatic exp_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    wrq.push_back(w);
  endtask

  task automatic wait_ack(input int p);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 24 && !got; i++) begin
      @(negedge clock);
      got = (p == 0) ? bus.ack0 : bus.ack1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout port%0d actual=no_ack required=ack at cycle %0d", p, cyc);
    end
  endtask

  // Hold the request until its ack, then release it in the following IDLE cycle.
  task automatic serve(input int p);
    wait_ack(p);
    @(posedge clock); #1;
    drive(p, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic rr_requester(input int p);
    for (int k = 0; k < 4; k++) begin
      wait_ack(p);
      @(posedge clock); #1;
      if (k < 3) drive(p, 1'b1, rr_we[p][k+1], rr_addr[p][k+1], rr_wd[p][k+1]);
      else       drive(p, 1'b0, 1'b0, 5'd0, 32'd0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int seen0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    bus.ram_output_data = '0;
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'd0);

    rr_we[0][0] = 0; rr_addr[0][0] = 5'd0;  rr_wd[0][0] = 0;            rr_exp[0][0] = 32'hA000_0000;
    rr_we[0][1] = 0; rr_addr[0][1] = 5'd31; rr_wd[0][1] = 0;            rr_exp[0][1] = 32'hA000_001F;
    rr_we[0][2] = 0; rr_addr[0][2] = 5'd31; rr_wd[0][2] = 0;            rr_exp[0][2] = 32'h5A5A_5A5A;
    rr_we[0][3] = 0; rr_addr[0][3] = 5'd3;  rr_wd[0][3] = 0;            rr_exp[0][3] = 32'hA000_0003;
    rr_we[1][0] = 0; rr_addr[1][0] = 5'd0;  rr_wd[1][0] = 0;            rr_exp[1][0] = 32'hA000_0000;
    rr_we[1][1] = 1; rr_addr[1][1] = 5'd31; rr_wd[1][1] = 32'h5A5A_5A5A; rr_exp[1][1] = 32'h0;
    rr_we[1][2] = 0; rr_addr[1][2] = 5'd5;  rr_wd[1][2] = 0;            rr_exp[1][2] = 32'hDEAD_BEEF;
    rr_we[1][3] = 0; rr_addr[1][3] = 5'd2;  rr_wd[1][3] = 0;            rr_exp[1][3] = 32'hA000_0002;

    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // contention straight after reset: requester 0 first
    @(posedge clock); #1; t = cyc;
    exp_ack(0, t + 3, 1'b1, 32'hA000_0001);
    exp_ack(1, t + 7, 1'b1, 32'hA000_0002);
    drive(0, 1'b1, 1'b0, 5'd1, 32'd0);
    drive(1, 1'b1, 1'b0, 5'd2, 32'd0);
    fork
      serve(0);
      serve(1);
    join

    // single write, then read back
    @(posedge clock); #1; t = cyc;
    exp_wr(t + 1, 5'd5, 32'hDEAD_BEEF);
    exp_ack(0, t + 3, 1'b0, 32'd0);
    drive(0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    serve(0);
    @(posedge clock); #1; t = cyc;
    exp_ack(0, t + 3, 1'b1, 32'hDEAD_BEEF);
    drive(0, 1'b1, 1'b0, 5'd5, 32'd0);
    serve(0);

    // requester 1 arrives while busy; requester 0 alters its inputs mid-flight
    @(posedge clock); #1; t = cyc;
    exp_ack(0, t + 3, 1'b1, 32'hDEAD_BEEF);
    exp_ack(1, t + 7, 1'b1, 32'hA000_0002);
    drive(0, 1'b1, 1'b0, 5'd5, 32'd0);
    fork
      begin
        @(posedge clock); #1;
        drive(0, 1'b1, 1'b1, 5'd7, 32'hBAD0_BAD0);
        serve(0);
      end
      begin
        @(posedge clock); #1;
        drive(1, 1'b1, 1'b0, 5'd2, 32'd0);
        serve(1);
      end
    join

    // both held continuously for 8 transactions: grants must alternate
    @(posedge clock); #1; t = cyc;
    for (int n = 0; n < 8; n++)
      exp_ack(n % 2, t + 3 + 4 * n, !rr_we[n % 2][n / 2], rr_exp[n % 2][n / 2]);
    exp_wr(t + 13, 5'd31, 32'h5A5A_5A5A);
    drive(0, 1'b1, rr_we[0][0], rr_addr[0][0], rr_wd[0][0]);
    drive(1, 1'b1, rr_we[1][0], rr_addr[1][0], rr_wd[1][0]);
    fork
      rr_requester(0);
      rr_requester(1);
    join

    // reset lands on the ACCESS cycle of a write to addr 9
    @(posedge clock); #1; t = cyc;
    seen0 = acks_seen;
    exp_wr(t + 1, 5'd9, 32'h1234_5678);
    drive(0, 1'b1, 1'b1, 5'd9, 32'h1234_5678);
    @(posedge clock); #1;
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("abort_no_ack", acks_seen, seen0);
    t = cyc;
    exp_ack(0, t + 3, 1'b1, 32'hA000_0009);
    drive(0, 1'b1, 1'b0, 5'd9, 32'd0);
    serve(0);

    repeat (3) @(posedge clock);
    #1;
    chk("ack_queue_drained", ackq.size(), 32'd0);
    chk("write_queue_drained", wrq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
